// File: rtl/spc700_pkg.sv
// Shared types and widths for the SPC700 audio RAM subsystem.
package spc700_pkg;
  localparam int ARAM_ADDR_W = 16;
  localparam int ARAM_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DSP  = 2'd1,
    OWN_CPU  = 2'd2
  } aram_owner_t;
endpackage

// File: rtl/aram_grant_select.sv
// Per-edge winner selection: DSP has fixed priority unless the CPU has been
// passed over MAX_DSP_STREAK times in a row.
module aram_grant_select
  import spc700_pkg::*;
#(
  parameter int MAX_DSP_STREAK = 4,
  parameter int STREAK_W       = $clog2(MAX_DSP_STREAK + 1)
) (
  input  logic                dsp_elig,
  input  logic                cpu_elig,
  input  logic [STREAK_W-1:0] streak,
  output logic [1:0]          owner
);
  aram_owner_t sel;

  always_comb begin
    sel = OWN_NONE;
    if (dsp_elig && cpu_elig)
      sel = (int'(streak) >= MAX_DSP_STREAK) ? OWN_CPU : OWN_DSP;
    else if (dsp_elig)
      sel = OWN_DSP;
    else if (cpu_elig)
      sel = OWN_CPU;
  end

  assign owner = sel;
endmodule

// File: rtl/aram_arbiter.sv
// Arbitrates the single-port audio RAM between the DSP and the SPC700 CPU,
// one outstanding access per requester, acks routed back by an owner tag pipe.
module aram_arbiter
  import spc700_pkg::*;
#(
  parameter int RAM_READ_LATENCY = 1,
  parameter int MAX_DSP_STREAK   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dsp_req,
  input  logic [15:0] dsp_addr,
  input  logic        dsp_we,
  input  logic [7:0]  dsp_wdata,
  output logic        dsp_ack,
  output logic [7:0]  dsp_rdata,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] ram_address,
  output logic [7:0]  ram_wdata,
  output logic        ram_write_enable,
  input  logic [7:0]  ram_rdata,
  output logic        cpu_stalled
);
  localparam int L        = RAM_READ_LATENCY;
  localparam int STREAK_W = $clog2(MAX_DSP_STREAK + 1);

  logic                dsp_busy, cpu_busy;
  logic                dsp_elig, cpu_elig;
  logic                dsp_done, cpu_done;
  logic [STREAK_W-1:0] streak;
  logic [1:0]          owner;
  logic [L:0][1:0]     tag_pipe;

  // busy stays set through the ack edge, so a req still held at that edge is ignored
  assign dsp_elig    = dsp_req && !dsp_busy;
  assign cpu_elig    = cpu_req && !cpu_busy;
  assign dsp_done    = (tag_pipe[L] == OWN_DSP);
  assign cpu_done    = (tag_pipe[L] == OWN_CPU);
  assign cpu_stalled = cpu_req && (owner != OWN_CPU);

  aram_grant_select #(
    .MAX_DSP_STREAK (MAX_DSP_STREAK),
    .STREAK_W       (STREAK_W)
  ) u_sel (
    .dsp_elig (dsp_elig),
    .cpu_elig (cpu_elig),
    .streak   (streak),
    .owner    (owner)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      dsp_busy         <= 1'b0;
      cpu_busy         <= 1'b0;
      streak           <= '0;
      tag_pipe         <= '0;
      dsp_ack          <= 1'b0;
      cpu_ack          <= 1'b0;
      dsp_rdata        <= '0;
      cpu_rdata        <= '0;
      ram_address      <= '0;
      ram_wdata        <= '0;
      ram_write_enable <= 1'b0;
    end else begin
      tag_pipe <= {tag_pipe[L-1:0], owner};
      dsp_ack  <= dsp_done;
      cpu_ack  <= cpu_done;
      if (dsp_done) dsp_rdata <= ram_rdata;
      if (cpu_done) cpu_rdata <= ram_rdata;

      if (owner == OWN_DSP)  dsp_busy <= 1'b1;
      else if (dsp_done)     dsp_busy <= 1'b0;
      if (owner == OWN_CPU)  cpu_busy <= 1'b1;
      else if (cpu_done)     cpu_busy <= 1'b0;

      ram_write_enable <= 1'b0;
      if (owner == OWN_DSP) begin
        ram_address      <= dsp_addr;
        ram_wdata        <= dsp_wdata;
        ram_write_enable <= dsp_we;
      end else if (owner == OWN_CPU) begin
        ram_address      <= cpu_addr;
        ram_wdata        <= cpu_wdata;
        ram_write_enable <= cpu_we;
      end

      if (owner == OWN_CPU || !cpu_elig)
        streak <= '0;
      else if (owner == OWN_DSP && streak < STREAK_W'(MAX_DSP_STREAK))
        streak <= streak + 1'b1;
    end
  end
endmodule

// File: tb/tb_aram_arbiter.sv
// Bench for aram_arbiter: directed corner sequences and a randomized run against
// a cycle-level model, on latency-1 and latency-3 instances.
module tb_aram_arbiter;
  import spc700_pkg::*;

  localparam int NI   = 2;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        dsp_req[NI], dsp_we[NI], cpu_req[NI], cpu_we[NI];
  logic [15:0] dsp_addr[NI], cpu_addr[NI], ram_addr[NI];
  logic [7:0]  dsp_wdata[NI], cpu_wdata[NI], dsp_rdata[NI], cpu_rdata[NI];
  logic [7:0]  ram_wd[NI], ram_rd[NI];
  logic        dsp_ack[NI], cpu_ack[NI], ram_we[NI], cpu_stalled[NI];

  aram_arbiter #(.RAM_READ_LATENCY(1), .MAX_DSP_STREAK(MAXS)) u_dut1 (
    .clock(clk), .reset(rst),
    .dsp_req(dsp_req[0]), .dsp_addr(dsp_addr[0]), .dsp_we(dsp_we[0]), .dsp_wdata(dsp_wdata[0]),
    .dsp_ack(dsp_ack[0]), .dsp_rdata(dsp_rdata[0]),
    .cpu_req(cpu_req[0]), .cpu_addr(cpu_addr[0]), .cpu_we(cpu_we[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]),
    .ram_address(ram_addr[0]), .ram_wdata(ram_wd[0]), .ram_write_enable(ram_we[0]),
    .ram_rdata(ram_rd[0]), .cpu_stalled(cpu_stalled[0]));

  aram_arbiter #(.RAM_READ_LATENCY(3), .MAX_DSP_STREAK(MAXS)) u_dut3 (
    .clock(clk), .reset(rst),
    .dsp_req(dsp_req[1]), .dsp_addr(dsp_addr[1]), .dsp_we(dsp_we[1]), .dsp_wdata(dsp_wdata[1]),
    .dsp_ack(dsp_ack[1]), .dsp_rdata(dsp_rdata[1]),
    .cpu_req(cpu_req[1]), .cpu_addr(cpu_addr[1]), .cpu_we(cpu_we[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]),
    .ram_address(ram_addr[1]), .ram_wdata(ram_wd[1]), .ram_write_enable(ram_we[1]),
    .ram_rdata(ram_rd[1]), .cpu_stalled(cpu_stalled[1]));

  // Standalone selector for table-driven priority/starvation vectors
  logic       gs_de, gs_ce;
  logic [2:0] gs_streak;
  logic [1:0] gs_owner;
  aram_grant_select #(.MAX_DSP_STREAK(MAXS), .STREAK_W(3)) u_sel (
    .dsp_elig(gs_de), .cpu_elig(gs_ce), .streak(gs_streak), .owner(gs_owner));

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return (a == 16'h1234) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h3C);
  endfunction

  // Behavioural RAMs: unwritten locations read as init_val
  bit   [7:0] ram_mem [NI][65536];
  bit         ram_wr  [NI][65536];
  logic [7:0] rd_pipe [NI][3];
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      rd_pipe[k][0] <= ram_wr[k][ram_addr[k]] ? ram_mem[k][ram_addr[k]] : init_val(ram_addr[k]);
      rd_pipe[k][1] <= rd_pipe[k][0];
      rd_pipe[k][2] <= rd_pipe[k][1];
      if (ram_we[k]) begin
        ram_mem[k][ram_addr[k]] <= ram_wd[k];
        ram_wr[k][ram_addr[k]]  <= 1'b1;
      end
    end
  end
  assign ram_rd[0] = rd_pipe[0][0];
  assign ram_rd[1] = rd_pipe[1][2];

  // Reference memory contents, updated in grant order
  logic [7:0] mref [int];
  function automatic logic [7:0] model_access(input int k, input logic [15:0] a,
                                              input logic we, input logic [7:0] wd);
    int key;
    logic [7:0] old;
    key = k * 65536 + int'(a);
    old = mref.exists(key) ? mref[key] : init_val(a);
    if (we) mref[key] = wd;
    return old;
  endfunction

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic access(input int k, input bit cpu, input logic [15:0] a, input logic we,
                        input logic [7:0] wd, output int edges, output logic [7:0] rd,
                        output int we_pulses, output int other_acks, output logic [15:0] first_addr);
    bit got;
    if (cpu) begin cpu_req[k] = 1'b1; cpu_addr[k] = a; cpu_we[k] = we; cpu_wdata[k] = wd; end
    else     begin dsp_req[k] = 1'b1; dsp_addr[k] = a; dsp_we[k] = we; dsp_wdata[k] = wd; end
    void'(model_access(k, a, we, wd));
    edges = 0; we_pulses = 0; other_acks = 0; rd = '0; first_addr = '0; got = 1'b0;
    while (!got && edges < 20) begin
      tick();
      edges++;
      if (edges == 1) first_addr = ram_addr[k];
      if (ram_we[k]) we_pulses++;
      if (cpu ? dsp_ack[k] : cpu_ack[k]) other_acks++;
      if (cpu ? cpu_ack[k] : dsp_ack[k]) begin
        rd  = cpu ? cpu_rdata[k] : dsp_rdata[k];
        got = 1'b1;
      end
    end
    if (cpu) cpu_req[k] = 1'b0; else dsp_req[k] = 1'b0;
  endtask

  task automatic new_req(input int k, input bit cpu);
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
    a = 16'h0300 + 16'($urandom_range(0, 7));
    w = 1'($urandom_range(0, 1));
    d = 8'($urandom);
    if (cpu) begin cpu_req[k] = 1'b1; cpu_addr[k] = a; cpu_we[k] = w; cpu_wdata[k] = d; end
    else     begin dsp_req[k] = 1'b1; dsp_addr[k] = a; dsp_we[k] = w; dsp_wdata[k] = d; end
  endtask

  // Model: requester is eligible from grant+2+L onward; ack lands at grant+1+L
  task automatic random_run(input int k, input int ncyc);
    int L, d_free, c_free, streak, d_ack_at, c_ack_at;
    logic [7:0] d_exp, c_exp;
    bit d_rd, c_rd;
    L = lat_of(k);
    d_free = 0; c_free = 0; streak = 0; d_ack_at = -1; c_ack_at = -1;
    d_exp = '0; c_exp = '0; d_rd = 1'b0; c_rd = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      bit de, ce, exp_we;
      int win;
      #1;
      de = dsp_req[k] && (c >= d_free);
      ce = cpu_req[k] && (c >= c_free);
      if (de && ce) win = (streak >= MAXS) ? 2 : 1;
      else if (de)  win = 1;
      else if (ce)  win = 2;
      else          win = 0;
      chk("rand_cpu_stalled", cpu_stalled[k], (cpu_req[k] && win != 2) ? 1 : 0);
      exp_we = 1'b0;
      if (win == 1) begin
        d_ack_at = c + 1 + L; d_free = c + 2 + L; d_rd = !dsp_we[k]; exp_we = dsp_we[k];
        d_exp = model_access(k, dsp_addr[k], dsp_we[k], dsp_wdata[k]);
      end else if (win == 2) begin
        c_ack_at = c + 1 + L; c_free = c + 2 + L; c_rd = !cpu_we[k]; exp_we = cpu_we[k];
        c_exp = model_access(k, cpu_addr[k], cpu_we[k], cpu_wdata[k]);
      end
      if (win == 2 || !ce) streak = 0;
      else if (win == 1 && streak < MAXS) streak++;
      tick();
      chk("rand_ram_we", ram_we[k], exp_we);
      chk("rand_dsp_ack", dsp_ack[k], (c == d_ack_at) ? 1 : 0);
      chk("rand_cpu_ack", cpu_ack[k], (c == c_ack_at) ? 1 : 0);
      if (c == d_ack_at && d_rd) chk("rand_dsp_rdata", dsp_rdata[k], d_exp);
      if (c == c_ack_at && c_rd) chk("rand_cpu_rdata", cpu_rdata[k], c_exp);
      if (!dsp_req[k] || c == d_ack_at) begin
        if ($urandom_range(0, 99) < 65) new_req(k, 1'b0); else dsp_req[k] = 1'b0;
      end
      if (!cpu_req[k] || c == c_ack_at) begin
        if ($urandom_range(0, 99) < 65) new_req(k, 1'b1); else cpu_req[k] = 1'b0;
      end
    end
    dsp_req[k] = 1'b0;
    cpu_req[k] = 1'b0;
    repeat (8) tick();
  endtask

  typedef struct {
    logic       de;
    logic       ce;
    logic [2:0] streak;
    logic [1:0] owner;
  } gs_vec_t;

  initial begin
    gs_vec_t     gs_tab[8];
    int          edges, wp, oa, L, d_edge, c_edge, ack_seen;
    logic [7:0]  rd, c_data;
    logic [15:0] fa;
    int          acks[$];

    gs_tab[0] = '{1'b0, 1'b0, 3'd0, OWN_NONE};
    gs_tab[1] = '{1'b1, 1'b0, 3'd0, OWN_DSP};
    gs_tab[2] = '{1'b0, 1'b1, 3'd0, OWN_CPU};
    gs_tab[3] = '{1'b1, 1'b1, 3'd0, OWN_DSP};
    gs_tab[4] = '{1'b1, 1'b1, 3'd3, OWN_DSP};
    gs_tab[5] = '{1'b1, 1'b1, 3'd4, OWN_CPU};
    gs_tab[6] = '{1'b0, 1'b1, 3'd4, OWN_CPU};
    gs_tab[7] = '{1'b1, 1'b0, 3'd4, OWN_DSP};

    for (int k = 0; k < NI; k++) begin
      dsp_req[k] = 1'b0; dsp_addr[k] = '0; dsp_we[k] = 1'b0; dsp_wdata[k] = '0;
      cpu_req[k] = 1'b0; cpu_addr[k] = '0; cpu_we[k] = 1'b0; cpu_wdata[k] = '0;
    end
    gs_de = 1'b0; gs_ce = 1'b0; gs_streak = '0;

    for (int i = 0; i < 8; i++) begin
      gs_de = gs_tab[i].de; gs_ce = gs_tab[i].ce; gs_streak = gs_tab[i].streak;
      #1;
      chk($sformatf("select_vec%0d", i), gs_owner, gs_tab[i].owner);
    end

    do_reset();
    for (int k = 0; k < NI; k++) begin
      chk("reset_ram_address", ram_addr[k], 0);
      chk("reset_ram_we", ram_we[k], 0);
      chk("reset_acks", {dsp_ack[k], cpu_ack[k]}, 0);
      chk("reset_rdata", {dsp_rdata[k], cpu_rdata[k]}, 0);
      chk("reset_cpu_stalled", cpu_stalled[k], 0);
    end

    // DSP read of preloaded location; ack edge count includes the grant edge
    for (int k = 0; k < NI; k++) begin
      L = lat_of(k);
      access(k, 1'b0, 16'h1234, 1'b0, 8'h00, edges, rd, wp, oa, fa);
      chk("t1_ram_address", fa, 16'h1234);
      chk("t1_latency", edges, 2 + L);
      chk("t1_rdata", rd, 8'hA5);
      chk("t1_cpu_ack", oa, 0);
      chk("t1_we_pulses", wp, 0);
      repeat (3) tick();
    end

    // CPU write then read back; then throughput under a continuously held read
    for (int k = 0; k < NI; k++) begin
      L = lat_of(k);
      access(k, 1'b1, 16'h00F0, 1'b1, 8'h3C, edges, rd, wp, oa, fa);
      chk("t2_write_latency", edges, 2 + L);
      chk("t2_write_pulses", wp, 1);
      access(k, 1'b1, 16'h00F0, 1'b0, 8'h00, edges, rd, wp, oa, fa);
      chk("t2_read_latency", edges, 2 + L);
      chk("t2_read_rdata", rd, 8'h3C);
      chk("t2_read_we_pulses", wp, 0);
      repeat (3) tick();
      acks.delete();
      cpu_req[k] = 1'b1; cpu_addr[k] = 16'h00F0; cpu_we[k] = 1'b0;
      for (int e = 1; e <= 3 * (2 + L) + 4; e++) begin
        if (e == 3 * (2 + L) + 1) cpu_req[k] = 1'b0;
        tick();
        if (cpu_ack[k]) begin
          acks.push_back(e);
          chk("t2_burst_rdata", cpu_rdata[k], 8'h3C);
        end
      end
      chk("t2_burst_acks", acks.size(), 3);
      if (acks.size() >= 2) chk("t2_burst_spacing", acks[1] - acks[0], 2 + L);
    end

    // Same-edge DSP write and CPU read of one address: DSP first, CPU sees new data
    for (int k = 0; k < NI; k++) begin
      L = lat_of(k);
      dsp_req[k] = 1'b1; dsp_addr[k] = 16'h0200; dsp_we[k] = 1'b1; dsp_wdata[k] = 8'h77;
      cpu_req[k] = 1'b1; cpu_addr[k] = 16'h0200; cpu_we[k] = 1'b0;
      void'(model_access(k, 16'h0200, 1'b1, 8'h77));
      d_edge = -1; c_edge = -1; c_data = '0;
      for (int e = 1; e <= 12; e++) begin
        tick();
        if (dsp_ack[k] && cpu_ack[k]) chk("t4_double_ack", 1, 0);
        if (dsp_ack[k]) begin d_edge = e; dsp_req[k] = 1'b0; end
        if (cpu_ack[k]) begin c_edge = e; c_data = cpu_rdata[k]; cpu_req[k] = 1'b0; end
      end
      dsp_req[k] = 1'b0; cpu_req[k] = 1'b0;
      chk("t4_dsp_ack_edge", d_edge, 2 + L);
      chk("t4_cpu_ack_edge", c_edge, 3 + L);
      chk("t4_cpu_rdata", c_data, 8'h77);
    end

    // Reset one cycle after a DSP read grant abandons the access
    dsp_req[0] = 1'b1; dsp_addr[0] = 16'h1234; dsp_we[0] = 1'b0;
    tick();
    chk("t5_grant_addr", ram_addr[0], 16'h1234);
    rst = 1'b1; dsp_req[0] = 1'b0;
    tick();
    chk("t5_reset_address", ram_addr[0], 0);
    chk("t5_reset_we", ram_we[0], 0);
    chk("t5_reset_dsp_ack", dsp_ack[0], 0);
    chk("t5_reset_dsp_rdata", dsp_rdata[0], 0);
    rst = 1'b0;
    ack_seen = 0;
    repeat (6) begin
      tick();
      ack_seen += int'(dsp_ack[0]);
    end
    chk("t5_no_ack_after_reset", ack_seen, 0);
    access(0, 1'b0, 16'h1234, 1'b0, 8'h00, edges, rd, wp, oa, fa);
    chk("t5_post_latency", edges, 3);
    chk("t5_post_rdata", rd, 8'hA5);

    for (int k = 0; k < NI; k++) begin
      do_reset();
      random_run(k, 400);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
